// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element array.
// Width derivations and slice-offset helpers used by pe_row and pe_wrapper,
// so that the packed-bus layouts are written down in exactly one place.
//   prod_width : width of one unsigned pixel*weight product
//   sum_width  : width of a row sum (product width plus KERNEL_SIZE guard bits)
//   pix_off    : bit offset of pixel c inside a pixel vector
//   wt_off     : bit offset of weight (r,c) inside the flattened weight matrix
//   sum_off    : bit offset of row r's sum inside the output bus
package pe_pkg;

  function automatic int prod_width(input int data_width, input int weight_width);
    return data_width + weight_width;
  endfunction

  function automatic int sum_width(input int data_width, input int weight_width,
                                   input int kernel_size);
    return data_width + weight_width + kernel_size;
  endfunction

  function automatic int pix_off(input int c, input int data_width);
    return c * data_width;
  endfunction

  function automatic int wt_off(input int r, input int c, input int kernel_size,
                                input int weight_width);
    return (r * kernel_size + c) * weight_width;
  endfunction

  function automatic int sum_off(input int r, input int sum_width_v);
    return r * sum_width_v;
  endfunction

endpackage

// File: rtl/pe_row.sv
// One row of the processing-element array.
// Forms the unsigned dot product of a pixel vector with this row's weights
// in two registered stages (products, then their sum).
// Ports:
//   clk, rstn : clock and synchronous active-low reset (clears all registers)
//   pixels    : KERNEL_SIZE pixels, pixel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   weights   : this row's KERNEL_SIZE weights, same packing by column
//   sum       : registered row sum, valid 2 cycles after pixels is presented
module pe_row
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int KERNEL_SIZE  = 3,
  localparam int PROD_WIDTH  = prod_width(DATA_WIDTH, WEIGHT_WIDTH),
  localparam int SUM_WIDTH   = sum_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]    pixels,
  input  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]  weights,
  output logic [SUM_WIDTH-1:0]                 sum
);

  logic [PROD_WIDTH-1:0] prod_p1 [KERNEL_SIZE];
  logic [SUM_WIDTH-1:0]  sum_next;
  logic [SUM_WIDTH-1:0]  sum_p2;

  // Stage 1: per-column products (weights are used live, not captured)
  always_ff @(posedge clk) begin
    for (int c = 0; c < KERNEL_SIZE; c++) begin
      if (!rstn) begin
        prod_p1[c] <= '0;
      end else begin
        prod_p1[c] <= PROD_WIDTH'(pixels[pix_off(c, DATA_WIDTH) +: DATA_WIDTH]) *
                      PROD_WIDTH'(weights[wt_off(0, c, KERNEL_SIZE, WEIGHT_WIDTH) +: WEIGHT_WIDTH]);
      end
    end
  end

  // KERNEL_SIZE guard bits cover the worst-case sum, so no saturation.
  always_comb begin
    sum_next = '0;
    for (int c = 0; c < KERNEL_SIZE; c++) begin
      sum_next = sum_next + SUM_WIDTH'(prod_p1[c]);
    end
  end

  // Stage 2: registered row sum
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sum_p2 <= '0;
    end else begin
      sum_p2 <= sum_next;
    end
  end

  assign sum = sum_p2;

endmodule

// File: rtl/pe_wrapper.sv
// Row-parallel convolution PE array.
// Accepts one column vector of KERNEL_SIZE pixels per enabled edge; row r
// computes the dot product with weight row r. The vector walks down the rows
// through a 2-register skew per row, so row r's result lags row 0's by 2*r.
// Ports:
//   clk, rstn    : clock and synchronous active-low reset
//   en           : accept dataIn this edge (a bubble loads zeros)
//   dataIn       : pixel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   weightsIn    : weight (r,c) at [(r*KERNEL_SIZE+c)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
//                  must stay stable while data is in flight
//   dataOut      : row r sum at [r*SUM_WIDTH +: SUM_WIDTH]
//   dataOut_done : some stage of the pipeline holds an accepted vector
module pe_wrapper
  import pe_pkg::*;
#(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  localparam int SUM_WIDTH   = sum_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE)
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  input  logic                                             en,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]                dataIn,
  input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]  weightsIn,
  output logic [SUM_WIDTH*KERNEL_SIZE-1:0]                 dataOut,
  output logic                                             dataOut_done
);

  localparam int VEC_WIDTH = DATA_WIDTH * KERNEL_SIZE;
  localparam int CHAIN_LEN = 2 * KERNEL_SIZE - 1;

  // vec_p[0] is the input register; vec_p[2r] feeds row r.
  logic [VEC_WIDTH-1:0]   vec_p [CHAIN_LEN];
  // vld_p[i] is set when a vector was accepted i edges ago.
  logic [2*KERNEL_SIZE:0] vld_p;

  // Stage 0: input register and vertical skew chain
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int j = 0; j < CHAIN_LEN; j++) begin
        vec_p[j] <= '0;
      end
      vld_p <= '0;
    end else begin
      vec_p[0] <= en ? dataIn : '0;
      for (int j = 1; j < CHAIN_LEN; j++) begin
        vec_p[j] <= vec_p[j-1];
      end
      vld_p <= {vld_p[2*KERNEL_SIZE-1:0], en};
    end
  end

  // vld_p[0] alone means the vector is still in the input register; the
  // window ends once the last row has shown it.
  assign dataOut_done = |vld_p[2*KERNEL_SIZE:1];

  for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
    pe_row #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .KERNEL_SIZE (KERNEL_SIZE)
    ) u_row (
      .clk    (clk),
      .rstn   (rstn),
      .pixels (vec_p[2*r]),
      .weights(weightsIn[wt_off(r, 0, KERNEL_SIZE, WEIGHT_WIDTH) +: WEIGHT_WIDTH*KERNEL_SIZE]),
      .sum    (dataOut[sum_off(r, SUM_WIDTH) +: SUM_WIDTH])
    );
  end

endmodule

// File: tb/tb_pe_wrapper.sv
// Self-checking bench for pe_wrapper: table vectors, hand sequences for the
// skew/done/bubble/reset corners, and random traffic against a reference
// model that keeps a history of accepted vectors per edge.
module tb_pe_wrapper;

  localparam int K  = 3;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int SW = DW + WW + K;

  logic              clk;
  logic              rstn;
  logic              en;
  logic [DW*K-1:0]   dataIn;
  logic [WW*K*K-1:0] weightsIn;
  logic [SW*K-1:0]   dataOut;
  logic              dataOut_done;

  pe_wrapper #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .dataIn      (dataIn),
    .weightsIn   (weightsIn),
    .dataOut     (dataOut),
    .dataOut_done(dataOut_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which edges accepted a vector, and what it was.
  int acc_v  [16];
  int acc_px [16][K];
  int wt     [K][K];
  int t = 100;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int row_out(input int r);
    return int'(dataOut[r*SW +: SW]);
  endfunction

  // Sum shown by row r after edge t: the vector accepted 2+2r edges earlier.
  function automatic int model_row(input int r);
    int e;
    int s;
    e = t - 2 - 2*r;
    s = 0;
    if (acc_v[e % 16] != 0)
      for (int c = 0; c < K; c++) s += acc_px[e % 16][c] * wt[r][c];
    return s;
  endfunction

  function automatic int model_done();
    int d;
    d = 0;
    for (int i = 1; i <= 2*K; i++) if (acc_v[(t - i) % 16] != 0) d = 1;
    return d;
  endfunction

  task automatic set_weight(input int r, input int c, input int v);
    weightsIn[(r*K + c)*WW +: WW] = WW'(v);
    wt[r][c] = v;
  endtask

  // One clock edge with the given inputs, then compare against the model.
  task automatic step(input logic rs, input logic e, input int p0, input int p1, input int p2);
    rstn   = rs;
    en     = e;
    dataIn = {DW'(p2), DW'(p1), DW'(p0)};
    @(posedge clk);
    t++;
    if (!rs) for (int i = 0; i < 16; i++) acc_v[i] = 0;
    acc_v[t % 16]     = (rs && e) ? 1 : 0;
    acc_px[t % 16][0] = p0;
    acc_px[t % 16][1] = p1;
    acc_px[t % 16][2] = p2;
    #1;
    for (int r = 0; r < K; r++) chk($sformatf("model_row%0d", r), row_out(r), model_row(r));
    chk("model_done", int'(dataOut_done), model_done());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 0);
  endtask

  typedef struct {
    int px [K];
    int w;
    int exp_sum;
  } vec_t;

  vec_t tbl [6];

  initial begin
    for (int i = 0; i < 16; i++) acc_v[i] = 0;
    rstn = 1'b0; en = 1'b0; dataIn = '0; weightsIn = '0;
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) wt[r][c] = 0;

    tbl[0] = '{px: '{1, 2, 3},       w: 1,   exp_sum: 6};
    tbl[1] = '{px: '{255, 255, 255}, w: 255, exp_sum: 195075};
    tbl[2] = '{px: '{0, 0, 0},       w: 200, exp_sum: 0};
    tbl[3] = '{px: '{10, 20, 30},    w: 2,   exp_sum: 120};
    tbl[4] = '{px: '{255, 0, 1},     w: 3,   exp_sum: 768};
    tbl[5] = '{px: '{7, 9, 11},      w: 17,  exp_sum: 459};

    // Reset held for 5 cycles with random inputs.
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < K; r++) for (int c = 0; c < K; c++)
        set_weight(r, c, $urandom_range(0, 255));
      step(1'b0, 1'(($urandom_range(0, 1))), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255));
      chk("reset_out", int'(dataOut != '0), 0);
      chk("reset_done", int'(dataOut_done), 0);
    end

    // Table: one vector each, uniform weights; row r checked at its skew slot.
    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) set_weight(r, c, tbl[v].w);
      step(1'b1, 1'b1, tbl[v].px[0], tbl[v].px[1], tbl[v].px[2]);
      for (int k = 1; k <= 2*K + 1; k++) begin
        step(1'b1, 1'b0, 0, 0, 0);
        for (int r = 0; r < K; r++)
          if (k == 2 + 2*r) chk($sformatf("tbl%0d_row%0d", v, r), row_out(r), tbl[v].exp_sum);
      end
    end

    // Wavefront: weights(r,c)=r+1, vectors [i,i+1,i+2] for i=0..4.
    begin
      int done_cnt;
      int first_done;
      done_cnt = 0;
      first_done = 1;
      for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) set_weight(r, c, r + 1);
      for (int s = 0; s < 17; s++) begin
        if (s < 5) step(1'b1, 1'b1, s, s + 1, s + 2);
        else       step(1'b1, 1'b0, 0, 0, 0);
        for (int r = 0; r < K; r++) begin
          int i;
          int exp;
          i = s - 2 - 2*r;
          exp = (i >= 0 && i < 5) ? (r + 1) * (3*i + 3) : 0;
          chk($sformatf("wave_s%0d_row%0d", s, r), row_out(r), exp);
        end
        chk($sformatf("wave_done_s%0d", s), int'(dataOut_done), (s >= 1 && s <= 10) ? 1 : 0);
        if (dataOut_done) begin
          if (first_done != 0) begin
            chk("wave_first_done_rows", int'(dataOut != '0), 0);
            first_done = 0;
          end
          done_cnt++;
        end
      end
      chk("wave_done_cycles", done_cnt, 5 + 2*K - 1);
    end

    // Bubble: en 1,0,1 with [1,1,1] and unit weights.
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) set_weight(r, c, 1);
    for (int s = 0; s < 11; s++) begin
      if (s == 0 || s == 2) step(1'b1, 1'b1, 1, 1, 1);
      else                  step(1'b1, 1'b0, 0, 0, 0);
      if (s >= 2 && s <= 4) chk($sformatf("bubble_row0_s%0d", s), row_out(0), (s == 3) ? 0 : 3);
      if (s >= 6 && s <= 8) chk($sformatf("bubble_row2_s%0d", s), row_out(2), (s == 7) ? 0 : 3);
    end

    // Mid-stream reset: in-flight data must never reappear.
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) set_weight(r, c, $urandom_range(1, 255));
    for (int s = 0; s < 3; s++)
      step(1'b1, 1'b1, $urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255));
    step(1'b0, 1'b1, 9, 9, 9);
    chk("midrst_out", int'(dataOut != '0), 0);
    chk("midrst_done", int'(dataOut_done), 0);
    for (int s = 0; s < 2*K + 2; s++) begin
      step(1'b1, 1'b0, 0, 0, 0);
      chk($sformatf("midrst_after_out_%0d", s), int'(dataOut != '0), 0);
      chk($sformatf("midrst_after_done_%0d", s), int'(dataOut_done), 0);
    end

    // Random traffic in rounds; weights change only once the pipe is drained.
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int r = 0; r < K; r++) for (int c = 0; c < K; c++)
        set_weight(r, c, (rnd == 3) ? 255 : $urandom_range(0, 255));
      for (int n = 0; n < 80; n++)
        step(1'(($urandom_range(0, 39) != 0)), 1'(($urandom_range(0, 3) != 0)),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      idle(2*K + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
